// File: rtl/gen_reduce_pipe.sv
// gen_reduce_pipe: pipelined CHUNK-ary bitwise reduction tree (AND/OR/XOR/NOR).
// Each tree level is one register stage. The op, tag and valid bits travel
// alongside the data through the same stages. The last node of a level with
// too few inputs is padded with the identity of that transaction's op.
// Optional feature macro: GEN_REDUCE_STALL_EN adds an out_ready port and a
// global stall. Without it the pipeline always advances and in_ready is tied 1.

// One tree node: CHUNK inputs in, one bit out.
module gen_reduce_node #(
    parameter int CHUNK = 4
) (
    input  logic [1:0]       op_i,
    input  logic [CHUNK-1:0] bits_i,
    output logic             bit_o
);

    // Combine the node inputs. NOR travels as OR and is inverted once at the output.
    always_comb begin
        bit_o = 1'b0;
        case (op_i)
            2'b00:   bit_o = &bits_i;
            2'b10:   bit_o = ^bits_i;
            default: bit_o = |bits_i;
        endcase
    end

endmodule

module gen_reduce_pipe #(
    parameter int WIDTH = 256,
    parameter int CHUNK = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
`ifdef GEN_REDUCE_STALL_EN
    input  logic             out_ready,
`endif
    output logic             out_valid,
    output logic             out_bit,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Smallest L with CHUNK**L >= w, never below 1 (a 1-bit input still gets a stage).
    function automatic int calc_levels(input int w, input int c);
        longint p;
        int     l;
        p = 1;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (p < longint'(w)) begin
                p = p * longint'(c);
                l++;
            end
        end
        return (l < 1) ? 1 : l;
    endfunction

    // Number of bits leaving level k (level 0 is the raw input).
    function automatic int width_at(input int w, input int c, input int k);
        int n;
        n = w;
        for (int i = 0; i < k; i++) n = (n + c - 1) / c;
        return n;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, CHUNK);

    logic                         adv;
    logic [LEVELS:1]              vld_pipe_q;
    logic [LEVELS:1][1:0]         op_q;
    logic [LEVELS:1][TAG_W-1:0]   tag_q;
    logic                         fin_bit;

`ifdef GEN_REDUCE_STALL_EN
    // A valid result the consumer refuses freezes every stage at once.
    logic stall;
    assign stall    = vld_pipe_q[LEVELS] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;
`else
    assign adv      = 1'b1;
    assign in_ready = 1'b1;
`endif

    // Sideband shift registers: valid, op and tag advance one stage per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            op_q       <= '0;
            tag_q      <= '0;
        end else if (adv) begin
            vld_pipe_q[1] <= in_valid & in_ready;
            op_q[1]       <= in_op;
            tag_q[1]      <= in_tag;
            for (int k = 2; k <= LEVELS; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                op_q[k]       <= op_q[k-1];
                tag_q[k]      <= tag_q[k-1];
            end
        end
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
        localparam int NI = width_at(WIDTH, CHUNK, lv - 1);
        localparam int NO = width_at(WIDTH, CHUNK, lv);

        logic [NI-1:0] src;
        logic [1:0]    op_s;
        logic [NO-1:0] node_o;
        logic [NO-1:0] data_q;

        // Level 1 reduces the live input; deeper levels reduce the previous stage.
        if (lv == 1) begin : g_first
            assign src  = in_bits;
            assign op_s = in_op;
        end else begin : g_inner
            assign src  = g_lvl[lv-1].data_q;
            assign op_s = op_q[lv-1];
        end

        for (genvar j = 0; j < NO; j++) begin : g_node
            logic [CHUNK-1:0] grp;
            for (genvar c = 0; c < CHUNK; c++) begin : g_in
                if (j * CHUNK + c < NI) begin : g_bit
                    assign grp[c] = src[j*CHUNK+c];
                end else begin : g_pad
                    // Identity padding: 1 for AND, 0 for OR/XOR/NOR.
                    assign grp[c] = (op_s == OP_AND);
                end
            end
            gen_reduce_node #(.CHUNK(CHUNK)) u_node (
                .op_i   (op_s),
                .bits_i (grp),
                .bit_o  (node_o[j])
            );
        end

        // Stage register for this level's partial results.
        always_ff @(posedge clk) begin
            if (rst)      data_q <= '0;
            else if (adv) data_q <= node_o;
        end

        if (lv == LEVELS) begin : g_last
            assign fin_bit = data_q[0];
        end
    end

    assign out_valid = vld_pipe_q[LEVELS];
    assign out_tag   = tag_q[LEVELS];
    assign out_bit   = fin_bit ^ (op_q[LEVELS] == OP_NOR);

endmodule

// File: tb/tb_gen_reduce_pipe.sv
// Directed and random bench for gen_reduce_pipe (WIDTH=256 and WIDTH=10 instances).
module tb_gen_reduce_pipe;

    localparam int W  = 256;
    localparam int LV = 4;
    localparam int TW = 4;
    localparam int HN = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  in_bits;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid, out_bit;
    logic [TW-1:0] out_tag;
    logic          out_ready;

    logic          s_valid, s_ready;
    logic [9:0]    s_bits;
    logic [1:0]    s_op;
    logic [TW-1:0] s_tag;
    logic          s_out_valid, s_out_bit;
    logic [TW-1:0] s_out_tag;
    logic          s_out_ready;

    gen_reduce_pipe #(.WIDTH(W), .CHUNK(4), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_bits(in_bits), .in_op(in_op), .in_tag(in_tag),
`ifdef GEN_REDUCE_STALL_EN
        .out_ready(out_ready),
`endif
        .out_valid(out_valid), .out_bit(out_bit), .out_tag(out_tag)
    );

    gen_reduce_pipe #(.WIDTH(10), .CHUNK(4), .TAG_W(TW)) dut10 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_ready),
        .in_bits(s_bits), .in_op(s_op), .in_tag(s_tag),
`ifdef GEN_REDUCE_STALL_EN
        .out_ready(s_out_ready),
`endif
        .out_valid(s_out_valid), .out_bit(s_out_bit), .out_tag(s_out_tag)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Expected-output history, indexed by the cycle the input was driven.
    logic          hv [HN];
    logic          hb [HN];
    logic [TW-1:0] ht [HN];
    logic          hr [HN];

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    endtask

    function automatic logic model(input logic [W-1:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return &b;
            2'b01:   return |b;
            2'b10:   return ^b;
            default: return ~|b;
        endcase
    endfunction

    // One cycle on the wide DUT: check outputs due now, then drive the next input.
    task automatic step(input logic r, input logic v, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [TW-1:0] tg, input logic eb);
        logic ev;
        @(negedge clk);
        ev = (cyc >= LV) ? hv[cyc-LV] : 1'b0;
        chk($sformatf("out_valid@%0d", cyc), 32'(out_valid), 32'(ev));
        if (ev) begin
            chk($sformatf("out_bit@%0d", cyc), 32'(out_bit), 32'(hb[cyc-LV]));
            chk($sformatf("out_tag@%0d", cyc), 32'(out_tag), 32'(ht[cyc-LV]));
        end
        if (cyc > 0 && hr[cyc-1]) begin
            chk($sformatf("rst_bit@%0d", cyc), 32'(out_bit), 32'd0);
            chk($sformatf("rst_tag@%0d", cyc), 32'(out_tag), 32'd0);
        end
        rst = r; in_valid = v; in_bits = b; in_op = op; in_tag = tg;
        hv[cyc] = v & ~r; hb[cyc] = eb; ht[cyc] = tg; hr[cyc] = r;
        if (r) for (int k = 1; k < LV; k++) if (cyc - k >= 0) hv[cyc-k] = 1'b0;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 2'b00, '0, 1'b0);
    endtask

    // One transaction through the 10-bit instance; result due two cycles later.
    task automatic w10(input string nm, input logic [9:0] b, input logic [1:0] op, input logic eb);
        s_valid = 1'b1; s_bits = b; s_op = op; s_tag = 4'd9;
        idle();
        s_valid = 1'b0;
        chk({nm, "_early"}, 32'(s_out_valid), 32'd0);
        idle();
        chk({nm, "_valid"}, 32'(s_out_valid), 32'd1);
        chk({nm, "_bit"}, 32'(s_out_bit), 32'(eb));
        chk({nm, "_tag"}, 32'(s_out_tag), 32'd9);
    endtask

`ifdef GEN_REDUCE_STALL_EN
    logic [W-1:0]  st_bits [6];
    logic [1:0]    st_op   [6];
    logic          st_exp  [6];
`endif

    logic [W-1:0] vb;
    logic [1:0]   rop;
    logic [TW-1:0] rtg;
    logic          rv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bits = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
        s_valid = 1'b0; s_bits = '0; s_op = '0; s_tag = '0; s_out_ready = 1'b1;
        for (int i = 0; i < HN; i++) begin hv[i] = 0; hb[i] = 0; ht[i] = '0; hr[i] = 0; end

        // Reset state
        step(1'b1, 1'b0, '0, 2'b00, '0, 1'b0);
        step(1'b1, 1'b0, '0, 2'b00, '0, 1'b0);
        idle();
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // T1: all ones AND, tag 5
        step(1'b0, 1'b1, '1, 2'b00, 4'd5, 1'b1);
        repeat (LV + 1) idle();

        // T2: four back-to-back transactions with different ops
        vb = '1; vb[255] = 1'b0;
        step(1'b0, 1'b1, vb, 2'b00, 4'd0, 1'b0);
        vb = '0; vb[0] = 1'b1;
        step(1'b0, 1'b1, vb, 2'b01, 4'd1, 1'b1);
        vb = '0; vb[0] = 1'b1; vb[7] = 1'b1; vb[200] = 1'b1;
        step(1'b0, 1'b1, vb, 2'b10, 4'd2, 1'b1);
        step(1'b0, 1'b1, '0, 2'b11, 4'd3, 1'b1);
        // Extra edge values: NOR of a single set bit, XOR of all ones
        vb = '0; vb[128] = 1'b1;
        step(1'b0, 1'b1, vb, 2'b11, 4'd4, 1'b0);
        step(1'b0, 1'b1, '1, 2'b10, 4'd6, 1'b0);
        repeat (LV + 1) idle();

        // T3: reset discards everything in flight
        step(1'b0, 1'b1, '1, 2'b00, 4'd7, 1'b1);
        step(1'b0, 1'b1, '1, 2'b01, 4'd8, 1'b1);
        step(1'b0, 1'b1, '1, 2'b11, 4'd9, 1'b0);
        step(1'b1, 1'b1, '1, 2'b00, 4'd10, 1'b1);
        repeat (LV + 2) idle();
        vb = '0; vb[77] = 1'b1;
        step(1'b0, 1'b1, vb, 2'b01, 4'd11, 1'b1);
        repeat (LV + 1) idle();

        // T4: non-power-of-CHUNK width exercises identity padding
        w10("w10_and1", 10'h3FF, 2'b00, 1'b1);
        w10("w10_xor89", 10'h300, 2'b10, 1'b0);
        w10("w10_or9", 10'h200, 2'b01, 1'b1);
        w10("w10_nor0", 10'h000, 2'b11, 1'b1);
        w10("w10_and_no9", 10'h1FF, 2'b00, 1'b0);
        w10("w10_xor9", 10'h200, 2'b10, 1'b1);

        // T6: random stream against the reference model
        for (int n = 0; n < 2000; n++) begin
            case ($urandom % 4)
                0: for (int k = 0; k < 8; k++) vb[k*32 +: 32] = $urandom;
                1: vb = '1;
                2: vb = '0;
                default: begin
                    vb = ($urandom % 2) ? '1 : '0;
                    vb[$urandom % W] = ~vb[0];
                end
            endcase
            rop = 2'($urandom % 4);
            rtg = TW'($urandom);
            rv  = ($urandom % 5) != 0;
            step(1'b0, rv, vb, rop, rtg, model(vb, rop));
        end
        repeat (LV + 1) idle();

`ifdef GEN_REDUCE_STALL_EN
        // T5: stall mid-stream; nothing lost, duplicated or changed while held
        begin
            int sent, got;
            logic pst, pb;
            logic [TW-1:0] pt;
            st_bits[0] = '1; st_op[0] = 2'b00; st_exp[0] = 1'b1;
            st_bits[1] = '0; st_op[1] = 2'b01; st_exp[1] = 1'b0;
            vb = '0; vb[3] = 1'b1;
            st_bits[2] = vb; st_op[2] = 2'b10; st_exp[2] = 1'b1;
            st_bits[3] = '0; st_op[3] = 2'b11; st_exp[3] = 1'b1;
            st_bits[4] = '0; st_op[4] = 2'b00; st_exp[4] = 1'b0;
            vb = '0; vb[1] = 1'b1; vb[2] = 1'b1;
            st_bits[5] = vb; st_op[5] = 2'b10; st_exp[5] = 1'b0;
            sent = 0; got = 0; pst = 1'b0; pb = 1'b0; pt = '0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                out_ready = !(c >= 4 && c < 7);
                #1;
                if (out_valid) begin
                    if (out_ready) begin
                        chk($sformatf("stall_bit%0d", got), 32'(out_bit), 32'(st_exp[got % 6]));
                        chk($sformatf("stall_tag%0d", got), 32'(out_tag), 32'(10 + got));
                        got++;
                    end else begin
                        chk("stall_in_ready", 32'(in_ready), 32'd0);
                        if (pst) begin
                            chk("stall_hold_bit", 32'(out_bit), 32'(pb));
                            chk("stall_hold_tag", 32'(out_tag), 32'(pt));
                        end
                    end
                end
                pst = out_valid & ~out_ready; pb = out_bit; pt = out_tag;
                if (sent < 6) begin
                    in_valid = 1'b1; in_bits = st_bits[sent]; in_op = st_op[sent];
                    in_tag = TW'(10 + sent);
                    if (in_ready) sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            chk("stall_sent", 32'(sent), 32'd6);
            chk("stall_got", 32'(got), 32'd6);
            chk("stall_drained", 32'(out_valid), 32'd0);
            out_ready = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
